// File: rtl/mem_arbiter.sv
// Purpose : N-port round-robin arbiter between cache-side requesters and the single main-memory port.
// Latency : grant on the edge a request is seen in IDLE; done/error pulse follows the edge memory done (or the watchdog) is sampled.
// Backpressure: one transaction at a time; non-granted ports read status 00 and simply wait.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_signal/addr/length/wdata     per-port request fields, port i at slice i
//   req_status                       per-port status: 00 none, 01 busy, 10 done, 11 error
//   rd_data                          read data, valid while the granted port reads 10
//   grant_id                         currently or last granted port
//   mem_vis_signal/addr/length/writen_data  latched memory-side request
//   mem_data, mem_status             memory response (mem_status 10 = done)
module mem_arbiter #(
  parameter int NUM_PORTS        = 2,
  parameter int PORT_INDEX_SIZE  = 1,
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int TIMEOUT          = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [2*NUM_PORTS-1:0]                  req_signal,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]         req_addr,
  input  logic [(ENTRY_INDEX_SIZE+1)*NUM_PORTS-1:0] req_length,
  input  logic [LEN*NUM_PORTS-1:0]                req_wdata,
  output logic [2*NUM_PORTS-1:0]                  req_status,
  output logic [LEN-1:0]                          rd_data,
  output logic [PORT_INDEX_SIZE-1:0]              grant_id,
  output logic [1:0]                              mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]                   mem_vis_addr,
  output logic [ENTRY_INDEX_SIZE:0]               mem_length,
  output logic [LEN-1:0]                          mem_writen_data,
  input  logic [LEN-1:0]                          mem_data,
  input  logic [1:0]                              mem_status
);

  localparam int LW = ENTRY_INDEX_SIZE + 1;
  // A disabled watchdog still needs a legal one-bit timer.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                       r_state;
  logic [PORT_INDEX_SIZE-1:0]   r_rr_ptr;
  logic [PORT_INDEX_SIZE-1:0]   r_gnt;
  logic [TW-1:0]                r_timer;
  logic [2*NUM_PORTS-1:0]       r_req_status;
  logic [LEN-1:0]               r_rd_data;
  logic [1:0]                   r_mem_sig;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [LW-1:0]                r_len;
  logic [LEN-1:0]               r_wdata;

  logic [NUM_PORTS-1:0]         w_valid;
  logic                         w_found;
  logic [PORT_INDEX_SIZE-1:0]   w_gnt;
  logic [1:0]                   w_sel_op;
  logic [ADDR_WIDTH-1:0]        w_sel_addr;
  logic [LW-1:0]                w_sel_len;
  logic [LEN-1:0]               w_sel_wdata;
  logic [LW-1:0]                w_len_c;
  logic                         w_done;
  logic                         w_tmo;
  logic [1:0]                   w_res;
  logic [2*NUM_PORTS-1:0]       w_busy_vec;
  logic [2*NUM_PORTS-1:0]       w_res_vec;
  logic [PORT_INDEX_SIZE-1:0]   w_rr_next;

  // Only read (01) and write (10) are real requests; 11 is treated as idle.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_valid[i] = (req_signal[2*i +: 2] == 2'b01) || (req_signal[2*i +: 2] == 2'b10);
    end
  end

  // First valid port scanning from rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin : arb
    int idx;
    idx         = 0;
    w_found     = 1'b0;
    w_gnt       = '0;
    w_sel_op    = 2'b00;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!w_found && w_valid[idx]) begin
        w_found     = 1'b1;
        w_gnt       = PORT_INDEX_SIZE'(idx);
        w_sel_op    = req_signal[2*idx +: 2];
        w_sel_addr  = req_addr[ADDR_WIDTH*idx +: ADDR_WIDTH];
        w_sel_len   = req_length[LW*idx +: LW];
        w_sel_wdata = req_wdata[LEN*idx +: LEN];
      end
    end
  end

  // Zero-length requests still move one word; oversize requests are cut to a full vector.
  always_comb begin
    w_len_c = w_sel_len;
    if (w_sel_len == '0) begin
      w_len_c = LW'(1);
    end else if (w_sel_len > LW'(VECTOR_SIZE)) begin
      w_len_c = LW'(VECTOR_SIZE);
    end
  end

  assign w_done = (mem_status == 2'b10);
  // Done takes priority over the watchdog when both land on the same edge.
  assign w_tmo  = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));
  assign w_res  = w_done ? 2'b10 : 2'b11;

  always_comb begin
    w_busy_vec = '0;
    w_res_vec  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PORT_INDEX_SIZE'(i) == w_gnt) w_busy_vec[2*i +: 2] = 2'b01;
      if (PORT_INDEX_SIZE'(i) == r_gnt) w_res_vec[2*i +: 2]  = w_res;
    end
  end

  // Explicit wrap so non-power-of-two port counts never point past the last port.
  assign w_rr_next = (int'(r_gnt) == NUM_PORTS - 1) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_timer      <= '0;
      r_req_status <= '0;
      r_rd_data    <= '0;
      r_mem_sig    <= 2'b00;
      r_addr       <= '0;
      r_len        <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt        <= w_gnt;
            r_mem_sig    <= w_sel_op;
            r_addr       <= w_sel_addr;
            r_len        <= w_len_c;
            r_wdata      <= w_sel_wdata;
            r_req_status <= w_busy_vec;
            r_timer      <= '0;
            r_state      <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (r_timer != {TW{1'b1}}) r_timer <= r_timer + 1'b1;
          if (w_done) begin
            // Writes leave the last read data in place.
            if (r_mem_sig == 2'b01) r_rd_data <= mem_data;
            r_req_status <= w_res_vec;
            r_mem_sig    <= 2'b00;
            r_state      <= S_RESP;
          end else if (w_tmo) begin
            r_rd_data    <= '0;
            r_req_status <= w_res_vec;
            r_mem_sig    <= 2'b00;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_req_status <= '0;
          r_rr_ptr     <= w_rr_next;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_status      = r_req_status;
  assign rd_data         = r_rd_data;
  assign grant_id        = r_gnt;
  assign mem_vis_signal  = r_mem_sig;
  assign mem_vis_addr    = r_addr;
  assign mem_length      = r_len;
  assign mem_writen_data = r_wdata;

endmodule
